// File: rtl/dsp48a1_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 MAC sequencer.
// OPM_ROUND_M is used only when DSP48A1_MAC_ROUND_EN is defined.
package dsp48a1_pkg;

  // OPMODE[1:0] = X mux, OPMODE[3:2] = Z mux; upper bits stay 0.
  localparam logic [7:0] OPM_LOAD_M  = 8'b0000_0001;
  localparam logic [7:0] OPM_ACC_M   = 8'b0000_1001;
  localparam logic [7:0] OPM_HOLD    = 8'b0000_1000;
  localparam logic [7:0] OPM_ROUND_M = 8'b0000_1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic live;
    logic first;
    logic last;
  } slot_tag_t;

  function automatic logic [7:0] slot_opmode(input slot_tag_t tag, input logic round_en);
    logic [7:0] opm;
    if (!tag.live) begin
      opm = OPM_HOLD;
    end else if (tag.first) begin
      opm = round_en ? OPM_ROUND_M : OPM_LOAD_M;
    end else begin
      opm = OPM_ACC_M;
    end
    return opm;
  endfunction

endpackage

// File: rtl/dsp48a1_tag_pipe.sv
// Enable-gated shift register with synchronous clear and async active-low reset.
// Carries slot tags and the delayed OPMODE alongside the DSP pipeline.
module dsp48a1_tag_pipe #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_clr) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_en) begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Streaming multiply-accumulate controller for one DSP48A1 slice (dot product of len pairs).
// Define DSP48A1_MAC_ROUND_EN to seed the accumulator with a round-half-up constant via C.
module dsp48a1_mac_sequencer
  import dsp48a1_pkg::*;
#(
  parameter int LEN_W     = 10,
  parameter int PIPE_LAT  = 3,
  parameter int OPM_REG   = 1,
  parameter int RND_SHIFT = 17
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    abort,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [17:0]      in_a,
  input  logic signed [17:0]      in_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [47:0]             res_p,
  output logic                    res_cout,
  output logic signed [17:0]      dsp_a,
  output logic signed [17:0]      dsp_b,
  output logic [47:0]             dsp_c,
  output logic [17:0]             dsp_d,
  output logic [7:0]              dsp_opmode,
  output logic                    dsp_ce,
  output logic                    dsp_rst,
  input  logic [47:0]             dsp_p,
  input  logic                    dsp_carryout
);

  localparam int          OPM_DLY   = PIPE_LAT - 1 - OPM_REG;
  localparam logic [47:0] RND_CONST = 48'd1 << (RND_SHIFT - 1);
`ifdef DSP48A1_MAC_ROUND_EN
  localparam logic        ROUND_EN  = 1'b1;
`else
  localparam logic        ROUND_EN  = 1'b0;
`endif
  localparam logic [47:0] C_INIT    = ROUND_EN ? RND_CONST : 48'd0;

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_remaining;
  logic             r_first;
  logic [47:0]      r_res_p, r_dsp_c;
  logic             r_res_cout, r_dsp_rst, r_dsp_ce;

  logic             w_abort, w_slot, w_accept, w_last_accept, w_start_idle, w_drain_hit;
  logic             w_unused_first;
  slot_tag_t        w_tag_in, w_tag_out;
  logic [7:0]       w_opm_in, w_opm_out;

  assign w_abort       = abort && (r_state != IDLE);
  assign w_start_idle  = start && (r_state == IDLE);
  assign w_slot        = (r_state == RUN) || (r_state == DRAIN);
  assign w_accept      = in_valid && (r_state == RUN);
  assign w_last_accept = w_accept && (r_remaining == LEN_W'(1));

  assign w_tag_in       = '{live: w_accept, first: w_accept && r_first, last: w_last_accept};
  assign w_opm_in       = slot_opmode(w_tag_in, ROUND_EN);
  assign w_drain_hit    = (r_state == DRAIN) && w_tag_out.live && w_tag_out.last;
  assign w_unused_first = w_tag_out.first;

  // Tag travels with the slot; it reaches the end exactly when P holds that slot's sum.
  dsp48a1_tag_pipe #(
    .WIDTH ($bits(slot_tag_t)),
    .DEPTH (PIPE_LAT)
  ) u_tag_pipe (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (w_slot),
    .i_clr   (w_abort || w_start_idle),
    .i_d     (w_tag_in),
    .o_q     (w_tag_out)
  );

  // OPMODE only advances on issued slots, so it holds P while idle or waiting on the result.
  dsp48a1_tag_pipe #(
    .WIDTH (8),
    .DEPTH (OPM_DLY)
  ) u_opm_pipe (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (w_slot),
    .i_clr   (w_abort),
    .i_d     (w_opm_in),
    .o_q     (w_opm_out)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (start) w_state_nxt = (len == '0) ? DONE : RUN;
        RUN:     if (w_last_accept) w_state_nxt = DRAIN;
        DRAIN:   if (w_drain_hit) w_state_nxt = DONE;
        DONE:    if (res_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != IDLE);
    in_ready  = (r_state == RUN);
    res_valid = (r_state == DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_res_p     <= '0;
      r_res_cout  <= 1'b0;
      r_dsp_rst   <= 1'b1;
      r_dsp_ce    <= 1'b0;
      r_dsp_c     <= '0;
    end else begin
      r_dsp_ce  <= 1'b1;
      r_dsp_c   <= C_INIT;
      r_dsp_rst <= w_abort;
      if (w_start_idle) begin
        r_remaining <= len;
        r_first     <= 1'b1;
        if (len == '0) begin
          r_res_p    <= C_INIT;
          r_res_cout <= 1'b0;
        end
      end else if (w_accept) begin
        r_remaining <= r_remaining - LEN_W'(1);
        r_first     <= 1'b0;
      end
      if (w_drain_hit && !w_abort) begin
        r_res_p    <= dsp_p;
        r_res_cout <= dsp_carryout;
      end
    end
  end

  assign dsp_a      = w_accept ? in_a : '0;
  assign dsp_b      = w_accept ? in_b : '0;
  assign dsp_c      = r_dsp_c;
  assign dsp_d      = '0;
  assign dsp_opmode = w_opm_out;
  assign dsp_ce     = r_dsp_ce;
  assign dsp_rst    = r_dsp_rst;
  assign res_p      = r_res_p;
  assign res_cout   = r_res_cout;

endmodule

// File: doc/dsp48a1_mac_sequencer.md
Name: dsp48a1_mac_sequencer

Overview:
Controller that drives one DSP48A1 slice as a streaming multiply-accumulate engine (dot product of LEN operand pairs).
- Accepts a start command with a length, then pulls (A,B) pairs over a valid/ready handshake.
- Sequences DSP48A1 OPMODE, clock-enable and reset so that sample 0 loads P and later samples accumulate.
- Returns the final P and CARRYOUT over a valid/ready result port. Sits between the filter/datapath front end and the DSP48A1 instance.

Parameters:
- LEN_W, 10, width of the length field; max run is 2^LEN_W-1 pairs.
- PIPE_LAT, 3, cycles from operand drive to the P register output (A1/B1 reg + MREG + PREG).
- OPM_REG, 1, OPMODE register depth inside the slice (OPMODEREG).
- RND_SHIFT, 17, rounding position used only with the optional feature.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  command pulse, sampled only in IDLE.
- len  in  LEN_W  number of pairs, sampled with start.
- abort  in  1  abandons the current run.
- busy  out  1  high whenever state != IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid && in_ready.
- in_a  in  18  operand A.
- in_b  in  18  operand B.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_p  out  48  accumulated result.
- res_cout  out  1  CARRYOUT captured with the result.
- dsp_a  out  18  to DSP A.
- dsp_b  out  18  to DSP B.
- dsp_c  out  48  to DSP C.
- dsp_d  out  18  to DSP D; constant 0.
- dsp_opmode  out  8  to DSP OPMODE.
- dsp_ce  out  1  drives all DSP CE* inputs.
- dsp_rst  out  1  drives all DSP RST* inputs (active-high).
- dsp_p  in  48  DSP P.
- dsp_carryout  in  1  DSP CARRYOUT.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs are 0, except dsp_rst=1 and dsp_opmode=8'h00.
  - dsp_rst deasserts on the first clock after RST_N rises.
  - dsp_ce=1 at all times outside reset.
- Slot model: each cycle in RUN/DRAIN issues one slot.
  - A slot is "live" if a pair was accepted that cycle, otherwise it is a "bubble". A bubble drives dsp_a=dsp_b=0.
  - A tag shift register of depth PIPE_LAT carries {live, first, last}.
- OPMODE timing:
  - dsp_opmode for a slot is driven PIPE_LAT-1-OPM_REG cycles after its operands (1 cycle at defaults).
  - first live slot: 8'b0000_0001 (X=M, Z=0).
  - subsequent live slots: 8'b0000_1001 (X=M, Z=P).
  - bubble slots: 8'b0000_1000 (X=0, Z=P; hold).
  - Bits 4-7 are always 0 (no pre-adder, no carry-in, no post-subtract).
- States:
  - IDLE: start with len!=0 → load remaining=len, go to RUN. start with len==0 → go to DONE with res_p=0, res_cout=0, no DSP activity.
  - RUN: in_ready=1. Each accepted pair decrements remaining. Accepting the pair that brings remaining to 0 sets last → DRAIN. in_valid low inserts bubbles; there is no stall timeout.
  - DRAIN: in_ready=0. When the last-tagged slot reaches the P output (PIPE_LAT cycles after issue), capture dsp_p/dsp_carryout → DONE.
  - DONE: res_valid=1 and held stable until res_ready. On the handshake → IDLE. start is ignored.
- Throughput and latency:
  - One pair per cycle sustained.
  - Last accept to res_valid is PIPE_LAT cycles.
  - Next start is accepted the cycle after the result handshake.
- Arithmetic: 18x18 signed into a 48-bit accumulator, wrapping two's-complement. Overflow is not flagged; res_cout reports the DSP CARRYOUT.
- Abort (any non-IDLE state, priority over everything):
  - Next state is IDLE and the tag pipe is cleared.
  - dsp_rst is pulsed for 1 cycle.
  - No res_valid is produced; any held result is dropped.
- Simultaneous events:
  - abort+start in IDLE: start wins (abort is ignored in IDLE).
  - res_ready without res_valid: ignored.
- RST_N asserted mid-run: immediate return to reset values; the partial sum is lost.

Optional Feature:
- Macro: DSP48A1_MAC_ROUND_EN.
- Defined:
  - The first live slot uses OPMODE 8'b0000_1101 (X=M, Z=C).
  - dsp_c = 48'd1 << (RND_SHIFT-1), constant, so the result is round-half-up at bit RND_SHIFT.
  - For len==0, res_p = that constant.
- Undefined: dsp_c=0 and the first-slot OPMODE is 8'b0000_0001.

Decomposition:
- Package dsp48a1_pkg:
  - OPMODE localparams OPM_LOAD_M, OPM_ACC_M, OPM_HOLD, OPM_ROUND_M.
  - State enum IDLE/RUN/DRAIN/DONE.
  - Tag struct {live, first, last}.
- Sub-module dsp48a1_tag_pipe: parameterised-depth shift register with synchronous clear, used for the slot tags and the OPMODE delay.

Test Plan:
- Reset: hold RST_N=0 → all outputs 0, dsp_rst=1, busy=0. Release RST_N → dsp_rst=0 after 1 clock.
- len=4, pairs (20,10),(5,6),(-3,7),(1,1) back-to-back → res_p=48'd210, res_valid exactly 3 cycles after the 4th accept, res_cout=0.
- len=3, pairs (2,3),(4,5),(6,7), with in_valid low for 2 cycles between pairs → res_p=68, and dsp_opmode=8'h08 in the bubble slots.
- len=2, (20,10),(5,6), res_ready held low 5 cycles → res_valid and res_p=230 stable throughout. start during DONE is ignored.
- len=5, abort after 2 pairs → busy=0 next cycle, 1-cycle dsp_rst pulse, no res_valid. A new len=1 run with (3,3) then returns 9.
- len=0 → res_valid with res_p=0 and no dsp_opmode change. With DSP48A1_MAC_ROUND_EN, len=1 with (1,1) returns 1+65536=65537.
